// File: rtl/access_pkg.sv
// Shared types for the access-control password checker: FSM state encoding,
// fail-counter width and a saturating increment helper.
package access_pkg;

  localparam int FAIL_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    GRANT,
    DENY,
    LOCK
  } state_t;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/access_scan_counter.sv
// Saturating counter with enable, synchronous clear/load and a terminal flag.
// Up mode stops at LAST (ROM address walk); down mode stops at 0 (lockout timer).
module access_scan_counter #(
  parameter int W       = 5,
  parameter int LAST    = 31,
  parameter bit DOWN    = 1'b0,
  parameter int CLR_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         fc
);

  localparam logic [W-1:0] TERM = DOWN ? '0 : W'(LAST);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(CLR_VAL);
    end else if (en && !fc) begin
      cnt_d = DOWN ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign fc  = (cnt_q == TERM);

endmodule

// File: rtl/access_ctrl_lockout.sv
// Password checker: on an enter edge, scans a registered-read ROM for the typed
// code, pulses granted/denied, and locks out after MAX_TRIES consecutive misses.
module access_ctrl_lockout
  import access_pkg::*;
#(
  parameter int PW_W      = 8,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter,
  input  logic [PW_W-1:0]   senha,
  output logic [AW-1:0]     mem_addr,
  input  logic [PW_W-1:0]   mem_data,
  output logic              busy,
  output logic              granted,
  output logic              denied,
  output logic              locked,
  output logic [AW-1:0]     match_idx,
  output logic [FAIL_W-1:0] fails
);

  localparam int TW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  state_t            state_q, state_d;
  logic              enter_q, armed_q, start;
  logic [PW_W-1:0]   code_q;
  logic              cmp_valid_q;
  logic [AW-1:0]     cmp_idx_q;
  logic              granted_q, denied_q;
  logic [AW-1:0]     match_idx_q;
  logic [FAIL_W-1:0] fails_q, fails_d, fails_inc;
  logic              hit, last_entry, grant_ev, deny_ev;
  logic [AW-1:0]     addr;
  logic              addr_fc_unused;
  logic [TW-1:0]     timer_cnt_unused;
  logic              timer_fc, timer_load;

  // armed_q blocks an enter that was already high when reset released.
  assign start      = enter & ~enter_q & armed_q & (state_q == IDLE);
  assign hit        = cmp_valid_q && (mem_data == code_q) && (mem_data != '0);
  assign last_entry = (cmp_idx_q == AW'(DEPTH - 1));
  assign fails_inc  = sat_inc(fails_q);
  assign timer_load = (state_d == LOCK) && (state_q != LOCK);

  access_scan_counter #(
    .W(AW), .LAST(DEPTH - 1), .DOWN(1'b0), .CLR_VAL(0)
  ) u_addr_cnt (
    .clk(clk), .rst(rst),
    .en(state_q == SCAN), .clr(state_d != SCAN),
    .cnt(addr), .fc(addr_fc_unused)
  );

  access_scan_counter #(
    .W(TW), .LAST(0), .DOWN(1'b1), .CLR_VAL(LOCK_CYC - 1)
  ) u_lock_timer (
    .clk(clk), .rst(rst),
    .en(state_q == LOCK), .clr(timer_load),
    .cnt(timer_cnt_unused), .fc(timer_fc)
  );

  always_comb begin
    state_d  = state_q;
    fails_d  = fails_q;
    grant_ev = 1'b0;
    deny_ev  = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        if (hit) begin
          state_d  = GRANT;
          grant_ev = 1'b1;
          fails_d  = '0;
        end else if (cmp_valid_q && last_entry) begin
          deny_ev = 1'b1;
          fails_d = fails_inc;
          state_d = (fails_inc == FAIL_W'(MAX_TRIES)) ? LOCK : DENY;
        end
      end
      GRANT, DENY: state_d = IDLE;
      LOCK: begin
        if (timer_fc) begin
          state_d = IDLE;
          fails_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      enter_q     <= 1'b0;
      armed_q     <= 1'b0;
      code_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
      granted_q   <= 1'b0;
      denied_q    <= 1'b0;
      match_idx_q <= '0;
      fails_q     <= '0;
    end else begin
      state_q     <= state_d;
      enter_q     <= enter;
      armed_q     <= armed_q | ~enter;
      if (start) code_q <= senha;
      // ROM data lags the address by one cycle, so the compared index does too.
      cmp_valid_q <= (state_q == SCAN) && (state_d == SCAN);
      cmp_idx_q   <= addr;
      granted_q   <= grant_ev;
      denied_q    <= deny_ev;
      if (grant_ev) match_idx_q <= cmp_idx_q;
      fails_q     <= fails_d;
    end
  end

  assign mem_addr  = addr;
  assign busy      = (state_q == SCAN);
  assign locked    = (state_q == LOCK);
  assign granted   = granted_q;
  assign denied    = denied_q;
  assign match_idx = match_idx_q;
  assign fails     = fails_q;

endmodule

// File: tb/tb_access_ctrl_lockout.sv
// Scoreboard bench: the driver computes each expected outcome from a plain ROM
// search and pushes it; a negedge monitor pops and compares on every pulse.
module tb_access_ctrl_lockout;

  localparam int PW_W      = 8;
  localparam int DEPTH     = 32;
  localparam int AW        = 5;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYC  = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enter = 1'b0;
  logic [PW_W-1:0] senha = '0;
  logic [AW-1:0]   mem_addr;
  logic [PW_W-1:0] mem_data;
  logic            busy, granted, denied, locked;
  logic [AW-1:0]   match_idx;
  logic [3:0]      fails;

  access_ctrl_lockout #(
    .PW_W(PW_W), .DEPTH(DEPTH), .AW(AW), .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enter(enter), .senha(senha),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .granted(granted), .denied(denied), .locked(locked),
    .match_idx(match_idx), .fails(fails)
  );

  always #5 clk = ~clk;

  logic [PW_W-1:0] rom [DEPTH];
  always @(posedge clk) mem_data <= rom[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         grant;
    int         idx;
    int         fails;
    bit         lock;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   fails_m = 0;
  // Expected busy / locked windows (inclusive cycle numbers) and scan start.
  int   bs = 1, be = 0, ls = 1, le = 0, ts = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  exp_t e;
  bit   eb, el;
  int   ea;
  logic locked_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      locked_prev = 1'b0;
    end else begin
      eb = (cyc >= bs) && (cyc <= be);
      el = (cyc >= ls) && (cyc <= le);
      ea = eb ? (((cyc - ts - 1) < DEPTH - 1) ? (cyc - ts - 1) : DEPTH - 1) : 0;
      chk("busy", int'(busy), int'(eb));
      chk("locked", int'(locked), int'(el));
      chk("mem_addr", int'(mem_addr), ea);
      if (granted || denied) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'({granted, denied}), 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", int'({granted, denied}), e.grant ? 2 : 1);
          chk("pulse_cycle", cyc, e.at);
          if (e.grant) chk("match_idx", int'(match_idx), e.idx);
          chk("fails_at_pulse", int'(fails), e.fails);
          chk("lock_with_pulse", int'(locked), int'(e.lock));
        end
      end
      if (locked_prev && !locked) chk("fails_after_lock", int'(fails), 0);
      locked_prev = locked;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic run_txn(input logic [PW_W-1:0] code, input int hold);
    int k, t0, tres;
    bit g, lk;
    @(negedge clk);
    k = -1;
    if (code != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rom[i] == code) begin
          k = i;
          break;
        end
      end
    end
    g    = (k >= 0);
    t0   = cyc;
    tres = g ? t0 + k + 3 : t0 + DEPTH + 2;
    fails_m = g ? 0 : ((fails_m == 15) ? 15 : fails_m + 1);
    lk   = !g && (fails_m == MAX_TRIES);
    sb.push_back('{g, g ? k : 0, fails_m, lk, tres});
    ts = t0; bs = t0 + 1; be = tres - 1;
    if (lk) begin
      ls = tres;
      le = tres + LOCK_CYC - 1;
    end
    senha = code;
    enter = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    senha = PW_W'($urandom);
    if (lk) begin
      // A fresh edge during lockout must be ignored entirely.
      wait_until(tres + 5);
      enter = 1'b1;
      @(negedge clk);
      enter = 1'b0;
    end
    wait_until((lk ? le : tres) + 2);
    if (lk) fails_m = 0;
    $display("[TB] txn code=%h hold=%0d expect %s idx=%0d fails=%0d lock=%0d",
             code, hold, g ? "grant" : "deny", g ? k : 0, lk ? MAX_TRIES : fails_m, lk);
  endtask

  logic [PW_W-1:0] pick;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h11;
    rom[0]  = 8'h00;
    rom[3]  = 8'hA5;
    rom[31] = 8'h5C;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_granted", int'(granted), 0);
    chk("rst_denied", int'(denied), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fails", int'(fails), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(8'hA5, 1);
    run_txn(8'h5C, 3);
    run_txn(8'h00, 2);
    run_txn(8'h22, 1);
    run_txn(8'h33, 4);
    run_txn(8'h44, 1);
    run_txn(8'h55, 1);
    run_txn(8'hA5, 2);
    run_txn(8'h66, 1);
    run_txn(8'h11, 10);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: pick = 8'hA5;
        1: pick = 8'h5C;
        2: pick = 8'h00;
        3: pick = 8'h11;
        default: pick = PW_W'($urandom);
      endcase
      run_txn(pick, $urandom_range(1, 10));
    end

    // Abort a scan with reset at t3, enter held high across the release.
    @(negedge clk);
    senha = 8'h5C;
    enter = 1'b1;
    ts = cyc; bs = cyc + 1; be = cyc + DEPTH + 1;
    wait_until(ts + 3);
    #2;
    rst = 1'b1;
    bs = 1; be = 0;
    sb.delete();
    fails_m = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_granted", int'(granted), 0);
    chk("abort_denied", int'(denied), 0);
    chk("abort_locked", int'(locked), 0);
    chk("abort_mem_addr", int'(mem_addr), 0);
    chk("abort_fails", int'(fails), 0);
    chk("abort_match_idx", int'(match_idx), 0);
    $display("[TB] txn reset mid-scan with enter held");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    enter = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(8'hA5, 10);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
